dac_multi_spi: RTL and testbench
================================

DAC_MULTI_SPI -- requirements
Module: dac_multi_spi

Interface
REQ-001 Parameter NUM_CH, default 8: number of AD5662 DACs served (range 1..16).
REQ-002 Parameter SCLK_DIV, default 2: dataclk cycles per SCLK half-period (range 1..15).
REQ-003 Parameter CH_W, default 3: channel index width; SHALL be at least ceil(log2(NUM_CH)).
REQ-004 dataclk  in  1  sole clock; all state changes on the rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 s_valid  in  1  a sample is offered.
REQ-007 s_ready  out  1  block accepts a sample this cycle.
REQ-008 s_channel  in  CH_W  target DAC index.
REQ-009 s_data  in  16  sample in unsigned offset format (0x8000 = zero).
REQ-010 hpf_en  in  1  high-pass filter output select.
REQ-011 hpf_coef  in  16  HPF coefficient B, unsigned.
REQ-012 hpf_clear  in  1  single-cycle pulse that zeroes all HPF states.
REQ-013 noise_suppress  in  7  dead-band half-width / 16.
REQ-014 gain  in  3  left-shift amount, saturating.
REQ-015 dac_en  in  NUM_CH  per-channel enable.
REQ-016 dac_sync  out  NUM_CH  per-DAC SYNC, active-low.
REQ-017 dac_sclk  out  1  shared SCLK.
REQ-018 dac_din  out  1  shared serial data.
REQ-019 dac_word  out  16  last word sent.
REQ-020 ch_err  out  1  one-cycle pulse when a sample has s_channel >= NUM_CH.

Function
REQ-021 Sample accept SHALL occur on an edge where s_valid=1 and s_ready=1; s_ready SHALL be 1 only in IDLE.
REQ-022 State machine states: IDLE -> CALC (1 cycle) -> LOAD (1 cycle) -> SHIFT (48*SCLK_DIV cycles) -> GAP (SCLK_DIV cycles) -> IDLE.
REQ-023 Out-of-range channel: the sample SHALL be accepted, ch_err pulsed in CALC, HPF state untouched, and FSM returned to IDLE without a frame.
REQ-024 CALC: x = {~s_data[15], s_data[14:0], 2'b00} (18-bit signed); d = x - state[ch][31:14], saturated to 0x1FFFF/0x20000.
REQ-025 CALC also: state[ch] <= state[ch] + (d * {1'b0, hpf_coef, 1'b0})[34:3], using 32-bit wrap-around.
REQ-026 hpf_clear SHALL zero all states and take priority over a same-cycle CALC update.
REQ-027 Filter output y SHALL be d[17:2] when hpf_en=1, otherwise x[17:2].
REQ-028 LOAD dead-band: with n = noise_suppress*16, y>=0 maps to max(y-n, 0) and y<0 maps to min(y+n, 0).
REQ-029 LOAD gain: the dead-band result SHALL be shifted left by gain, saturating to 0x7FFF/0x8000.
REQ-030 LOAD output: the result SHALL be converted to offset format and latched into dac_word; the value 0x8000 is forced when dac_en[ch]=0.
REQ-031 On the LOAD edge, dac_sync[ch] SHALL go low and the 24-bit frame {6'b0, 2'b00 power-down, dac_word} shall be loaded.
REQ-032 SHIFT bit timing: each bit SHALL be driven on dac_din while dac_sclk is low for SCLK_DIV cycles, then dac_sclk is high for SCLK_DIV cycles; bits are sent MSB first (the DAC samples on the falling edge).
REQ-033 After bit 0, dac_sclk SHALL be low and dac_sync[ch] high for the whole of GAP.
REQ-034 At most one dac_sync bit SHALL be low at any time.
REQ-035 Accept-to-SYNC-low latency SHALL be 2 cycles; accept-to-next-s_ready latency SHALL be 2 + 49*SCLK_DIV cycles.

Reset
REQ-036 While reset_n=0, independent of dataclk, the block SHALL drive: dac_sync all 1, dac_sclk 0, dac_din 0, dac_word 0x8000, ch_err 0, s_ready 0, FSM IDLE, all HPF states 0.
REQ-037 s_ready SHALL rise on the first edge after reset_n deasserts.
REQ-038 A reset during a frame SHALL abort it immediately, with no resumption after release.

Configuration
REQ-039 With macro DAC_HPF_EN defined, the block SHALL include the per-channel 32-bit states, the 18x18 multiplier, hpf_en, hpf_coef and hpf_clear.
REQ-040 With DAC_HPF_EN undefined, there SHALL be no states and no multiplier, y = x[17:2] always, hpf_* ports remain present but are ignored, and timing is unchanged.

Verification
REQ-041 Reset check: release reset_n -> dac_sync=0xFF, dac_sclk=0, dac_din=0, dac_word=0x8000; s_ready=1 one edge after release.
REQ-042 Plain frame: hpf_en=0, gain=0, noise_suppress=0, dac_en=0xFF, send ch2 0x1234 -> only dac_sync[2] low for 48*SCLK_DIV cycles; 24 falling-edge bits read 0x001234.
REQ-043 Disabled channel and saturation: dac_en[1]=0, send ch1 0xC000 -> word 0x8000; dac_en all high, gain=3, send 0xC000 -> word 0xFFFF.
REQ-044 Dead-band and range check: noise_suppress=10, send 0x8050 -> word 0x8000; send ch 9 with NUM_CH=8 -> one ch_err pulse, no SYNC activity.
REQ-045 HPF: hpf_en=1, hpf_coef=0, constant 0x9000 -> every word 0x9000; hpf_coef=0x4000, constant 0x9000 -> words decrease monotonically to 0x8000+/-2 within 100 samples; hpf_clear then resends -> 0x9000 again.
REQ-046 Reset mid-frame: assert reset_n=0 during bit 10 -> dac_sync all 1 and dac_sclk 0 with no dataclk edge; after release the next ch0 frame is unfiltered-equivalent (state 0).

Source files
------------

// File: rtl/dac_multi_spi_if.sv
// -----------------------------------------------------------------------------
// dac_multi_spi_if
// Sample handshake bundle between a sample producer and dac_multi_spi.
//
// Parameter:
//   CH_W       channel index width (must match the DAC block's CH_W)
// Signals:
//   s_valid    producer offers a sample
//   s_ready    DAC block can accept a sample this cycle
//   s_channel  target DAC index
//   s_data     sample, unsigned offset format (0x8000 = zero)
// Modports:
//   master     producer side (drives valid/channel/data)
//   slave      DAC block side (drives ready)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
interface dac_multi_spi_if #(
  parameter int CH_W = 3
) ();
  logic            s_valid;
  logic            s_ready;
  logic [CH_W-1:0] s_channel;
  logic [15:0]     s_data;

  modport master (output s_valid, output s_channel, output s_data, input s_ready);
  modport slave  (input s_valid, input s_channel, input s_data, output s_ready);
endinterface

// File: rtl/dac_multi_spi.sv
// -----------------------------------------------------------------------------
// dac_multi_spi
// Drives up to 16 AD5662 DACs over one shared SCLK/DIN pair with a private
// active-low SYNC per DAC. Each accepted sample is optionally high-pass
// filtered (per-channel first-order DC tracker), passed through a dead band
// and a saturating gain, converted back to offset binary and shifted out as a
// 24-bit frame {6'b0, 2'b00 (normal power mode), word}, MSB first.
//
// Build option:
//   DAC_HPF_EN  when defined, the per-channel 32-bit filter states and the
//               18x18 multiplier are built and hpf_en/hpf_coef/hpf_clear are
//               live; when undefined those ports are ignored and y = x.
//
// Parameters: NUM_CH (1..16), SCLK_DIV (1..15 clocks per SCLK half period),
//             CH_W (>= ceil(log2(NUM_CH))).
// Ports:
//   dataclk, reset_n    clock, asynchronous active-low reset
//   s                   sample handshake (slave modport)
//   hpf_en/hpf_coef     filter output select / coefficient B
//   hpf_clear           one-cycle pulse that zeroes all filter states
//   noise_suppress      dead-band half-width in units of 16 LSB
//   gain                saturating left shift
//   dac_en              per-channel enable (disabled channel outputs 0x8000)
//   dac_sync            per-DAC SYNC, active low
//   dac_sclk, dac_din   shared serial clock and data
//   dac_word            last word sent
//   ch_err              one-cycle pulse for an out-of-range channel
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module dac_multi_spi #(
  parameter int NUM_CH   = 8,
  parameter int SCLK_DIV = 2,
  parameter int CH_W     = 3
) (
  input  logic              dataclk,
  input  logic              reset_n,
  dac_multi_spi_if.slave    s,
  input  logic              hpf_en,
  input  logic [15:0]       hpf_coef,
  input  logic              hpf_clear,
  input  logic [6:0]        noise_suppress,
  input  logic [2:0]        gain,
  input  logic [NUM_CH-1:0] dac_en,
  output logic [NUM_CH-1:0] dac_sync,
  output logic              dac_sclk,
  output logic              dac_din,
  output logic [15:0]       dac_word,
  output logic              ch_err
);

  localparam int         IDX_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [3:0] DIV_LAST = 4'(SCLK_DIV - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CALC,
    ST_LOAD,
    ST_SHIFT,
    ST_GAP
  } state_t;

  state_t            state_q, state_d;
  logic              ready_q;
  logic [CH_W-1:0]   ch_q;
  logic [15:0]       data_q;
  logic [15:0]       y_q;
  logic [15:0]       word_q;
  logic [23:0]       shreg_q;
  logic [NUM_CH-1:0] sync_q;
  logic              sclk_q;
  logic [4:0]        bit_q;
  logic [3:0]        div_q;

  logic              accept;
  logic              ch_ok;
  logic [IDX_W-1:0]  idx;
  logic              div_last;
  logic [15:0]       y_calc;
  logic [15:0]       word_calc;
  logic [NUM_CH-1:0] sel_n;

  assign accept   = (state_q == ST_IDLE) && s.s_valid && ready_q;
  assign ch_ok    = int'(ch_q) < NUM_CH;
  assign idx      = ch_q[IDX_W-1:0];
  assign div_last = (div_q == DIV_LAST);

  assign s.s_ready = ready_q;
  assign ch_err    = (state_q == ST_CALC) && !ch_ok;
  assign dac_sync  = sync_q;
  assign dac_sclk  = sclk_q;
  assign dac_din   = shreg_q[23];
  assign dac_word  = word_q;

  // ---------------------------------------------------------------------------
  // Filter: x is the sample as 18-bit two's complement (2 guard LSBs); the
  // state's top 18 bits track the DC level of x, d = x - DC.
  // ---------------------------------------------------------------------------
`ifdef DAC_HPF_EN
  logic        [31:0] st_q [NUM_CH];
  logic signed [17:0] x_s, hi_s, d_s;
  logic        [18:0] diff;
  logic signed [35:0] prod;
  logic               unused_prod_bits;

  assign x_s  = {~data_q[15], data_q[14:0], 2'b00};
  assign hi_s = st_q[idx][31:14];
  assign diff = {x_s[17], x_s} - {hi_s[17], hi_s};
  // Saturate when the 19-bit difference does not fit in 18 bits.
  assign d_s  = (diff[18] != diff[17]) ? (diff[18] ? 18'h20000 : 18'h1FFFF)
                                       : diff[17:0];
  assign prod = d_s * $signed({1'b0, hpf_coef, 1'b0});
  assign unused_prod_bits = ^{prod[35], prod[2:0]};
  assign y_calc = hpf_en ? d_s[17:2] : x_s[17:2];

  // NOTE: the filter states are a small register array, not a RAM, so they
  // take the asynchronous reset like any other state.
  always_ff @(posedge dataclk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) st_q[i] <= '0;
    end else if (hpf_clear) begin
      for (int i = 0; i < NUM_CH; i++) st_q[i] <= '0;
    end else if (state_q == ST_CALC && ch_ok) begin
      st_q[idx] <= st_q[idx] + prod[34:3];
    end
  end
`else
  logic unused_hpf;
  assign unused_hpf = ^{hpf_en, hpf_coef, hpf_clear};
  assign y_calc     = {~data_q[15], data_q[14:0]};
`endif

  // ---------------------------------------------------------------------------
  // Dead band, saturating gain, offset conversion (evaluated during LOAD).
  // ---------------------------------------------------------------------------
  logic signed [16:0] y17, n17, dn, up, db;
  logic signed [23:0] sh;
  logic        [15:0] r;

  // NOTE: every variable written in an always_comb gets a value on every path
  // (here by straight-line assignment before any branch) so no latch is built.
  always_comb begin
    y17 = {y_q[15], y_q};
    n17 = {6'b0, noise_suppress, 4'b0000};
    dn  = y17 - n17;
    up  = y17 + n17;
    db  = '0;
    if (!y_q[15]) begin
      if (!dn[16]) db = dn;
    end else begin
      if (up[16]) db = up;
    end
    sh = {{7{db[16]}}, db} <<< gain;
    if (sh > 24'sd32767)       r = 16'h7FFF;
    else if (sh < -24'sd32768) r = 16'h8000;
    else                       r = sh[15:0];
    word_calc = dac_en[idx] ? {~r[15], r[14:0]} : 16'h8000;
  end

  always_comb begin
    sel_n = '1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (int'(idx) == i) sel_n[i] = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame sequencer.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (accept) state_d = ST_CALC;
      ST_CALC:  state_d = ch_ok ? ST_LOAD : ST_IDLE;
      ST_LOAD:  state_d = ST_SHIFT;
      // The last SCLK falling edge (end of bit 0) closes the frame.
      ST_SHIFT: if (div_last && sclk_q && bit_q == 5'd23) state_d = ST_GAP;
      ST_GAP:   if (div_last) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge dataclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == ST_IDLE);
    end
  end

  always_ff @(posedge dataclk or negedge reset_n) begin
    if (!reset_n) begin
      ch_q    <= '0;
      data_q  <= 16'h8000;
      y_q     <= '0;
      word_q  <= 16'h8000;
      shreg_q <= '0;
      sync_q  <= '1;
      sclk_q  <= 1'b0;
      bit_q   <= '0;
      div_q   <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            ch_q   <= s.s_channel;
            data_q <= s.s_data;
          end
        end
        ST_CALC: y_q <= y_calc;
        ST_LOAD: begin
          word_q  <= word_calc;
          shreg_q <= {8'h00, word_calc};
          sync_q  <= sel_n;
          sclk_q  <= 1'b0;
          bit_q   <= '0;
          div_q   <= '0;
        end
        ST_SHIFT: begin
          if (div_last) begin
            div_q  <= '0;
            sclk_q <= ~sclk_q;
            if (sclk_q) begin
              shreg_q <= {shreg_q[22:0], 1'b0};
              bit_q   <= bit_q + 5'd1;
              if (bit_q == 5'd23) sync_q <= '1;
            end
          end else begin
            div_q <= div_q + 4'd1;
          end
        end
        ST_GAP:  div_q <= div_last ? 4'd0 : div_q + 4'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dac_multi_spi.sv
// -----------------------------------------------------------------------------
// tb_dac_multi_spi
// Bench for dac_multi_spi. A behavioural model (integer arithmetic on the
// sample, per-channel DC state, dead band, gain, clamp) predicts each frame
// word; a monitor decodes every SYNC frame from the serial pins and compares
// it, its channel, length and latency against the prediction. Directed cases
// pin literal words; a randomized phase sweeps channels and settings.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dac_multi_spi;
  localparam int NUM_CH    = 8;
  localparam int SCLK_DIV  = 2;
  localparam int CH_W      = 4;
  localparam int FRAME_CYC = 48 * SCLK_DIV;
  localparam int LAT_READY = 2 + 49 * SCLK_DIV;

  logic              dataclk = 1'b0;
  logic              reset_n = 1'b0;
  logic              hpf_en = 1'b0;
  logic [15:0]       hpf_coef = '0;
  logic              hpf_clear = 1'b0;
  logic [6:0]        noise_suppress = '0;
  logic [2:0]        gain = '0;
  logic [NUM_CH-1:0] dac_en = '1;
  logic [NUM_CH-1:0] dac_sync;
  logic              dac_sclk, dac_din, ch_err;
  logic [15:0]       dac_word;

  dac_multi_spi_if #(.CH_W(CH_W)) s_if ();

  dac_multi_spi #(.NUM_CH(NUM_CH), .SCLK_DIV(SCLK_DIV), .CH_W(CH_W)) dut (
    .dataclk(dataclk), .reset_n(reset_n), .s(s_if),
    .hpf_en(hpf_en), .hpf_coef(hpf_coef), .hpf_clear(hpf_clear),
    .noise_suppress(noise_suppress), .gain(gain), .dac_en(dac_en),
    .dac_sync(dac_sync), .dac_sclk(dac_sclk), .dac_din(dac_din),
    .dac_word(dac_word), .ch_err(ch_err)
  );

  always #5 dataclk = ~dataclk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  int m_st [NUM_CH];

  function automatic logic [15:0] model_word(input int ch, input logic [15:0] data);
    int x, y, n, r;
`ifdef DAC_HPF_EN
    int d;
    longint p;
`endif
    x = (int'(data) - 32768) * 4;
    y = x / 4;
`ifdef DAC_HPF_EN
    d = x - (m_st[ch] >>> 14);
    if (d > 131071)  d = 131071;
    if (d < -131072) d = -131072;
    p = longint'(d) * longint'(hpf_coef) * 2;
    m_st[ch] = m_st[ch] + int'(p >>> 3);
    if (hpf_en) y = d >>> 2;
`endif
    n = int'(noise_suppress) * 16;
    if (y >= 0) y = (y > n) ? y - n : 0;
    else        y = (y < -n) ? y + n : 0;
    r = y * (1 << gain);
    if (r > 32767)  r = 32767;
    if (r < -32768) r = -32768;
    return dac_en[ch] ? 16'(r + 32768) : 16'h8000;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < NUM_CH; i++) m_st[i] = 0;
  endtask

  typedef struct {
    int          ch;
    logic [15:0] word;
  } exp_t;

  exp_t exp_q[$];
  time  t_acc = 0;
  int   sync_falls = 0;
  int   err_pulses = 0;

  // ---------------------------------------------------------------------------
  // Monitor: decodes frames from the pins on every falling dataclk edge.
  // ---------------------------------------------------------------------------
  logic        prev_sclk = 1'b0, prev_din = 1'b0;
  bit          in_frame = 1'b0;
  int          low_cnt, nbits, fr_ch;
  logic [23:0] bits;

  always @(negedge dataclk) begin
    if (!reset_n) begin
      in_frame  = 1'b0;
      exp_q.delete();
      prev_sclk = 1'b0;
      prev_din  = 1'b0;
    end else begin
      if (ch_err) err_pulses++;
      check("sync_at_most_one_low", 32'($countones(~dac_sync) <= 1), 32'd1);
      if (in_frame) begin
        if (prev_sclk && !dac_sclk) begin
          bits = {bits[22:0], prev_din};
          nbits++;
        end
        if (&dac_sync) begin
          in_frame = 1'b0;
          check("frame_len", 32'(low_cnt), 32'(FRAME_CYC));
          check("frame_nbits", 32'(nbits), 32'd24);
          if (exp_q.size() == 0) begin
            check("frame_unexpected", 32'd1, 32'd0);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("frame_ch", 32'(fr_ch), 32'(e.ch));
            check("frame_bits", 32'(bits), {16'h0000, e.word});
            check("dac_word", 32'(dac_word), 32'(e.word));
          end
        end else begin
          low_cnt++;
        end
      end else if (!(&dac_sync)) begin
        in_frame = 1'b1;
        low_cnt  = 1;
        nbits    = 0;
        bits     = '0;
        sync_falls++;
        for (int i = 0; i < NUM_CH; i++) if (!dac_sync[i]) fr_ch = i;
        check("sync_latency", 32'($time - t_acc), 32'd25);
        check("sclk_low_at_sync", 32'(dac_sclk), 32'd0);
      end else begin
        check("sclk_idle_low", 32'(dac_sclk), 32'd0);
      end
      prev_sclk = dac_sclk;
      prev_din  = dac_din;
    end
  end

  // ---------------------------------------------------------------------------
  // Driver
  // ---------------------------------------------------------------------------
  task automatic send(input int ch, input logic [15:0] data, input bit clr_calc,
                      input bit wait_done);
    int k, e0, f0, lat;
    @(negedge dataclk);
    k = 0;
    while (!s_if.s_ready && k < 1000) begin
      @(negedge dataclk);
      k++;
    end
    if (!s_if.s_ready) begin
      check("ready_timeout_before", 32'd0, 32'd1);
      return;
    end
    s_if.s_valid   = 1'b1;
    s_if.s_channel = ch[CH_W-1:0];
    s_if.s_data    = data;
    @(posedge dataclk);
    t_acc = $time;
    e0 = err_pulses;
    f0 = sync_falls;
    if (ch < NUM_CH) begin
      exp_t e;
      e.ch   = ch;
      e.word = model_word(ch, data);
      exp_q.push_back(e);
    end
    if (clr_calc) clear_model();
    @(negedge dataclk);
    s_if.s_valid = 1'b0;
    hpf_clear    = clr_calc;
    @(negedge dataclk);
    hpf_clear = 1'b0;
    if (!wait_done) return;
    k = 0;
    while (!s_if.s_ready && k < 1000) begin
      @(negedge dataclk);
      k++;
    end
    if (!s_if.s_ready) begin
      check("ready_timeout_after", 32'd0, 32'd1);
      return;
    end
    lat = int'(($time - t_acc - 5) / 10);
    @(negedge dataclk);
    if (ch < NUM_CH) begin
      check("ready_latency", 32'(lat), 32'(LAT_READY));
      check("ch_err_quiet", 32'(err_pulses - e0), 32'd0);
    end else begin
      check("ch_err_pulse", 32'(err_pulses - e0), 32'd1);
      check("bad_ch_no_sync", 32'(sync_falls - f0), 32'd0);
    end
  endtask

  task automatic release_reset();
    @(negedge dataclk);
    reset_n = 1'b1;
    #1;
    check("ready_low_before_edge", 32'(s_if.s_ready), 32'd0);
    @(negedge dataclk);
    check("ready_after_release", 32'(s_if.s_ready), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sync"},  32'(dac_sync), 32'(8'hFF));
    check({tag, "_sclk"},  32'(dac_sclk), 32'd0);
    check({tag, "_din"},   32'(dac_din), 32'd0);
    check({tag, "_word"},  32'(dac_word), 32'h8000);
    check({tag, "_err"},   32'(ch_err), 32'd0);
    check({tag, "_ready"}, 32'(s_if.s_ready), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] prev_w;
    s_if.s_valid   = 1'b0;
    s_if.s_channel = '0;
    s_if.s_data    = 16'h8000;
    clear_model();

    // Reset state
    #12;
    check_reset_outputs("reset");
    release_reset();

    // Plain frame on channel 2
    send(2, 16'h1234, 1'b0, 1'b1);
    check("lit_plain", 32'(dac_word), 32'h1234);

    // Disabled channel and gain saturation
    dac_en = 8'hFD;
    send(1, 16'hC000, 1'b0, 1'b1);
    check("lit_disabled", 32'(dac_word), 32'h8000);
    dac_en = 8'hFF;
    gain   = 3'd3;
    send(1, 16'hC000, 1'b0, 1'b1);
    check("lit_gain_sat", 32'(dac_word), 32'hFFFF);
    send(4, 16'h2000, 1'b0, 1'b1);
    check("lit_gain_sat_neg", 32'(dac_word), 32'h0000);
    gain = 3'd0;

    // Dead band and out-of-range channel
    noise_suppress = 7'd10;
    send(3, 16'h8050, 1'b0, 1'b1);
    check("lit_deadband", 32'(dac_word), 32'h8000);
    send(3, 16'h80B0, 1'b0, 1'b1);
    check("lit_deadband_edge", 32'(dac_word), 32'h8010);
    send(9, 16'h4321, 1'b0, 1'b1);
    noise_suppress = 7'd0;

    // HPF: zero coefficient leaves the DC untouched
    hpf_en = 1'b1;
    hpf_coef = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      send(5, 16'h9000, 1'b0, 1'b1);
      check("lit_hpf_coef0", 32'(dac_word), 32'h9000);
    end

    // HPF: DC decays towards mid-scale
    hpf_coef = 16'h4000;
    prev_w = 16'hFFFF;
    for (int i = 0; i < 40; i++) begin
      send(6, 16'h9000, 1'b0, 1'b1);
      check("hpf_monotonic", 32'(dac_word <= prev_w), 32'd1);
      prev_w = dac_word;
    end
`ifdef DAC_HPF_EN
    check("hpf_settled", 32'(dac_word >= 16'h7FFE && dac_word <= 16'h8002), 32'd1);
`else
    check("hpf_ignored", 32'(dac_word), 32'h9000);
`endif
    @(negedge dataclk);
    hpf_clear = 1'b1;
    clear_model();
    @(negedge dataclk);
    hpf_clear = 1'b0;
    send(6, 16'h9000, 1'b0, 1'b1);
    check("lit_hpf_cleared", 32'(dac_word), 32'h9000);

    // Reset in the middle of a frame (bit 10)
    send(0, 16'h9000, 1'b0, 1'b1);
    send(0, 16'h9000, 1'b0, 1'b1);
    send(0, 16'hA000, 1'b0, 1'b0);
    repeat (20 * SCLK_DIV + 1) @(posedge dataclk);
    #3;
    check("pre_abort_sync0_low", 32'(dac_sync[0]), 32'd0);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    clear_model();
    repeat (3) @(posedge dataclk);
    check("abort_held_sync", 32'(dac_sync), 32'(8'hFF));
    release_reset();
    send(0, 16'h9000, 1'b0, 1'b1);
    check("lit_after_abort", 32'(dac_word), 32'h9000);

    // Randomized sweep
    for (int i = 0; i < 60; i++) begin
      int ch;
      ch             = $urandom_range(0, 9);
      dac_en         = NUM_CH'($urandom | $urandom);
      gain           = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'd0;
      noise_suppress = ($urandom_range(0, 2) == 0) ? 7'($urandom) : 7'd0;
      hpf_en         = 1'($urandom);
      hpf_coef       = 16'($urandom);
      if ($urandom_range(0, 9) == 0) begin
        @(negedge dataclk);
        hpf_clear = 1'b1;
        clear_model();
        @(negedge dataclk);
        hpf_clear = 1'b0;
      end
      send(ch, 16'($urandom), ($urandom_range(0, 7) == 0), 1'b1);
    end

    repeat (5) @(negedge dataclk);
    check("exp_queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
